reg_writeback_unit: RTL and testbench

Write-side front end of the 16-bit register file. Accepts result writes from two producers (ALU and load/memory unit) over valid/ready handshakes, arbitrates round-robin, buffers results in a small FIFO, and drains one entry per cycle onto the register file's single write port (reg_wr_addr/reg_wr_data/reg_wr_en). Exports a per-register pending mask that decode uses for hazard stalls.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/reg_writeback_unit.sv | 152 +++++++++++++++
 tb/tb_reg_writeback_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
// The optional result-forwarding port is enabled by defining WB_FWD_EN.
package wb_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int NUM_REGS  = 7;
    localparam int NUM_ADDRS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // Addresses at or above NUM_REGS have no backing register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries. Besides push/pop it exposes a
// per-slot valid vector and the stored addresses so the top level can build
// the pending mask; with WB_FWD_EN it also exposes slot data and the read
// pointer for age-ordered forwarding lookups.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
`ifdef WB_FWD_EN
    ,
    output logic [DEPTH-1:0][DATA_W-1:0]  entry_data,
    output logic [$clog2(DEPTH)-1:0]      rd_ptr_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] push_mask;
    logic [DEPTH-1:0] pop_mask;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // One-hot slot masks for the valid-vector update.
    always_comb begin
        push_mask = '0;
        pop_mask  = '0;
        if (do_push) push_mask[wr_ptr] = 1'b1;
        if (do_pop)  pop_mask[rd_ptr]  = 1'b1;
    end

    // Flatten stored addresses (and data when forwarding) for the top level.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
`ifdef WB_FWD_EN
            entry_data[i] = mem[i].data;
`endif
        end
    end

`ifdef WB_FWD_EN
    assign rd_ptr_out = rd_ptr;
`endif

    // Storage array; contents are qualified by entry_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // Pointers wrap naturally; occupancy is tracked in its own counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            entry_valid <= (entry_valid & ~pop_mask) | push_mask;
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side front end of the register file: round-robin arbitration between
// the ALU and load unit, a small result FIFO, a registered write port and a
// per-register pending mask for decode hazard stalls.
// Define WB_FWD_EN to add the fwd_addr/fwd_hit/fwd_data lookup port.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_addr,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    reg_wr_en,
    output logic [ADDR_W-1:0]       reg_wr_addr,
    output logic [DATA_W-1:0]       reg_wr_data,
    output logic [NUM_ADDRS-1:0]    pending,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    bad_addr
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]       fwd_addr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_src_e                     rr_ptr;
    logic                        grant_alu;
    logic                        grant_mem;
    logic                        accept;
    logic                        both_valid;
    wb_entry_t                   sel_entry;
    logic                        sel_ok;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    wb_entry_t                   fifo_head;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
`ifdef WB_FWD_EN
    logic [DEPTH-1:0][DATA_W-1:0] entry_data;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W-1:0]            fwd_idx;
`endif

    // Grant goes to the sole requester, or to the round-robin owner on a tie.
    always_comb begin
        both_valid = alu_valid & mem_valid;
        grant_alu  = alu_valid & (~mem_valid | (rr_ptr == SRC_ALU));
        grant_mem  = mem_valid & (~alu_valid | (rr_ptr == SRC_MEM));
        alu_ready  = grant_alu & ~fifo_full;
        mem_ready  = grant_mem & ~fifo_full;
        accept     = (alu_valid & alu_ready) | (mem_valid & mem_ready);
        sel_entry  = grant_alu ? '{addr: alu_addr, data: alu_data}
                               : '{addr: mem_addr, data: mem_data};
        sel_ok     = addr_in_range(sel_entry.addr);
        fifo_push  = accept & sel_ok;
        fifo_pop   = (fifo_count != '0);
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .push_entry  (sel_entry),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .full        (fifo_full),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
`ifdef WB_FWD_EN
        ,
        .entry_data  (entry_data),
        .rd_ptr_out  (rd_ptr)
`endif
    );

    // Round-robin owner flips only when a contested cycle resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SRC_ALU;
        end else if (both_valid && accept) begin
            rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end
    end

    // Sticky flag for accepted writes aimed at a non-existent register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_addr <= 1'b0;
        end else if (accept && !sel_ok) begin
            bad_addr <= 1'b1;
        end
    end

    // Output stage drains one FIFO entry per cycle; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else if (fifo_pop) begin
            reg_wr_en   <= 1'b1;
            reg_wr_addr <= fifo_head.addr;
            reg_wr_data <= fifo_head.data;
        end else begin
            reg_wr_en   <= 1'b0;
        end
    end

    // Pending mask built purely from registered FIFO and output-stage state.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pending[entry_addr[i]] = 1'b1;
        end
        if (reg_wr_en) pending[reg_wr_addr] = 1'b1;
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest matching result wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (reg_wr_en && (reg_wr_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = reg_wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if (entry_valid[fwd_idx] && (entry_addr[fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: a vector table with hand-derived
// handshake expectations, a scoreboard queue of accepted results, and short
// hand-written sequences for invalid addresses, same-register ordering and
// reset in the middle of traffic. Define WB_FWD_EN to also check forwarding.
module tb_reg_writeback_unit;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 alu_valid;
    logic                 alu_ready;
    logic [ADDR_W-1:0]    alu_addr;
    logic [DATA_W-1:0]    alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_data;
    logic                 reg_wr_en;
    logic [ADDR_W-1:0]    reg_wr_addr;
    logic [DATA_W-1:0]    reg_wr_data;
    logic [NUM_ADDRS-1:0] pending;
    logic [CNT_W-1:0]     fifo_count;
    logic                 bad_addr;
`ifdef WB_FWD_EN
    logic [ADDR_W-1:0]    fwd_addr;
    logic                 fwd_hit;
    logic [DATA_W-1:0]    fwd_data;
`endif

    reg_writeback_unit #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .pending     (pending),
        .fifo_count  (fifo_count),
        .bad_addr    (bad_addr)
`ifdef WB_FWD_EN
        ,
        .fwd_addr    (fwd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              mv;
        logic [ADDR_W-1:0] ma;
        logic [DATA_W-1:0] md;
        logic              exp_ar;
        logic              exp_mr;
        logic [ADDR_W-1:0] fa;
    } vec_t;

    // Reference state: scoreboard of accepted-but-not-yet-written results and
    // the expected contents of the registered write port.
    wb_entry_t         sb_q[$];
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic              m_bad;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    function automatic vec_t mkVec(input logic av, input logic [ADDR_W-1:0] aa,
                                   input logic [DATA_W-1:0] ad, input logic mv,
                                   input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                                   input logic ear, input logic emr,
                                   input logic [ADDR_W-1:0] fa);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md;
        v.exp_ar = ear; v.exp_mr = emr; v.fa = fa;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        sb_q.delete();
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_bad     = 1'b0;
    endtask

    // Compare every observable output against the reference state.
    task automatic checkOutput(input vec_t v);
        logic [NUM_ADDRS-1:0] pend;
`ifdef WB_FWD_EN
        logic              e_hit;
        logic [DATA_W-1:0] e_data;
`endif
        pend = '0;
        foreach (sb_q[i]) pend[sb_q[i].addr] = 1'b1;
        if (m_wr_en) pend[m_wr_addr] = 1'b1;
        checkVal("alu_ready",   32'(alu_ready),   32'(v.exp_ar));
        checkVal("mem_ready",   32'(mem_ready),   32'(v.exp_mr));
        checkVal("reg_wr_en",   32'(reg_wr_en),   32'(m_wr_en));
        checkVal("reg_wr_addr", 32'(reg_wr_addr), 32'(m_wr_addr));
        checkVal("reg_wr_data", 32'(reg_wr_data), 32'(m_wr_data));
        checkVal("pending",     32'(pending),     32'(pend));
        checkVal("fifo_count",  32'(fifo_count),  32'(sb_q.size()));
        checkVal("bad_addr",    32'(bad_addr),    32'(m_bad));
`ifdef WB_FWD_EN
        e_hit  = 1'b0;
        e_data = '0;
        if (m_wr_en && m_wr_addr == v.fa) begin
            e_hit  = 1'b1;
            e_data = m_wr_data;
        end
        foreach (sb_q[i]) begin
            if (sb_q[i].addr == v.fa) begin
                e_hit  = 1'b1;
                e_data = sb_q[i].data;
            end
        end
        checkVal("fwd_hit", 32'(fwd_hit), 32'(e_hit));
        if (e_hit) checkVal("fwd_data", 32'(fwd_data), 32'(e_data));
`endif
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), check
    // mid-cycle, then advance the reference across the next rising edge.
    task automatic applyStimulus(input vec_t v);
        wb_entry_t e;
        alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
`ifdef WB_FWD_EN
        fwd_addr = v.fa;
`endif
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            m_wr_en   = 1'b1;
            m_wr_addr = e.addr;
            m_wr_data = e.data;
        end else begin
            m_wr_en = 1'b0;
        end
        e.addr = '0;
        e.data = '0;
        if (v.av && v.exp_ar) begin
            e.addr = v.aa; e.data = v.ad;
        end else if (v.mv && v.exp_mr) begin
            e.addr = v.ma; e.data = v.md;
        end
        if ((v.av && v.exp_ar) || (v.mv && v.exp_mr)) begin
            if (int'(e.addr) < NUM_REGS) sb_q.push_back(e);
            else m_bad = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 2));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Vector table; ready expectations derived by hand from the
        // round-robin owner, which starts at ALU after reset.
        tbl.push_back(mkVec(1, 3, 16'h1234, 0, 0, 16'h0000, 1, 0, 3)); // only ALU
        tbl.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3));
        tbl.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3));
        tbl.push_back(mkVec(1, 1, 16'hA001, 1, 2, 16'hB002, 1, 0, 1)); // owner ALU -> MEM
        tbl.push_back(mkVec(1, 4, 16'hA004, 1, 5, 16'hB005, 0, 1, 4)); // owner MEM -> ALU
        tbl.push_back(mkVec(1, 6, 16'hA006, 1, 0, 16'hB000, 1, 0, 5)); // -> MEM
        tbl.push_back(mkVec(1, 1, 16'hA011, 1, 2, 16'hB012, 0, 1, 6)); // -> ALU
        tbl.push_back(mkVec(0, 0, 16'h0000, 1, 3, 16'hB013, 0, 1, 2)); // only MEM, owner stays ALU
        tbl.push_back(mkVec(1, 4, 16'hA014, 1, 5, 16'hB015, 1, 0, 3)); // -> MEM
        tbl.push_back(mkVec(1, 0, 16'hA020, 0, 0, 16'h0000, 1, 0, 4)); // only ALU, owner stays MEM
        tbl.push_back(mkVec(1, 6, 16'hA026, 1, 1, 16'hB021, 0, 1, 0)); // -> ALU
        tbl.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6));

        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
`ifdef WB_FWD_EN
        fwd_addr = 2;
`endif
        modelReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 2));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table-driven arbitration and drain");
        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

        $display("[TB] invalid destination address");
        applyStimulus(mkVec(1, 7, 16'hDEAD, 0, 0, 0, 1, 0, 7));
        idle(3);

        $display("[TB] two writes to the same register");
        applyStimulus(mkVec(1, 2, 16'h0001, 0, 0, 0, 1, 0, 2));
        applyStimulus(mkVec(1, 2, 16'h0002, 0, 0, 0, 1, 0, 2));
        idle(3);

        $display("[TB] reset in the middle of traffic");
        applyStimulus(mkVec(1, 1, 16'h1111, 1, 4, 16'h4444, 1, 0, 1)); // owner -> MEM
        alu_valid = 1; alu_addr = 5; alu_data = 16'h5555;
        mem_valid = 1; mem_addr = 6; mem_data = 16'h6666;
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("rst_reg_wr_en",  32'(reg_wr_en),  32'(0));
        checkVal("rst_fifo_count", 32'(fifo_count), 32'(0));
        checkVal("rst_pending",    32'(pending),    32'(0));
        checkVal("rst_bad_addr",   32'(bad_addr),   32'(0));
        alu_valid = 0; mem_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        applyStimulus(mkVec(1, 2, 16'h2222, 1, 3, 16'h3333, 1, 0, 2)); // owner back to ALU
        applyStimulus(mkVec(1, 2, 16'h2223, 1, 3, 16'h3334, 0, 1, 3));
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
